uart_transmitter: RTL and testbench

Serial transmit side of the UART link: accepts a parallel data word and emits one frame per word on a single line.
- Frame, LSB first: start bit (0), DATA_WIDTH data bits, one parity bit, one stop bit (1).
- One bit period equals one `Baud_Clk` cycle, matching the sampling rate of our receive path, so `Tx_Out` drives the receiver's `Rx_In` directly.
- A one-word holding register lets the next word be queued while the current frame is on the line, so back-to-back frames leave no idle gap.

---
 rtl/uart_transmitter.sv | 132 +++++++++++++
 tb/tb_uart_transmitter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_transmitter.sv
// rtl/uart_transmitter.sv - UART frame serializer (start, data LSB first, parity, stop) with one-word holding register
module uart_transmitter #(
    parameter int DATA_WIDTH = 32,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic                  Baud_Clk,
    input  logic                  Reset,
    input  logic                  Tx_Start,
    input  logic [DATA_WIDTH-1:0] Tx_DataIn,
    output logic                  Tx_Out,
    output logic                  Tx_Ready,
    output logic                  Tx_Busy,
    output logic                  Tx_Done
);
    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic                  hold_v_q, hold_v_d;
    logic                  parity_q, parity_d;
    logic                  tx_out_q, tx_out_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  accept;
    logic                  direct_ok;
    logic                  load_en;
    logic [DATA_WIDTH-1:0] load_word;

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        hold_d    = hold_q;
        hold_v_d  = hold_v_q;
        parity_d  = parity_q;
        cnt_d     = cnt_q;
        load_en   = 1'b0;
        load_word = Tx_DataIn;
        accept    = Tx_Start && !hold_v_q;
        direct_ok = (state_q == IDLE) || ((state_q == STOP) && !hold_v_q);

        if (accept && !direct_ok) begin
            hold_d   = Tx_DataIn;
            hold_v_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    load_en = 1'b1;
                end
            end
            START: begin
                state_d = DATA;
            end
            DATA: begin
                shift_d = shift_q >> 1;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST_BIT) begin
                    state_d = PARITY;
                end
            end
            PARITY: begin
                state_d = STOP;
            end
            STOP: begin
                // A queued word wins; a direct write can only land when the holding register is empty.
                if (hold_v_q) begin
                    load_en   = 1'b1;
                    load_word = hold_q;
                    hold_v_d  = 1'b0;
                end else if (accept) begin
                    load_en = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (load_en) begin
            shift_d  = load_word;
            parity_d = (^load_word) ^ PARITY_ODD;
            cnt_d    = '0;
            state_d  = START;
        end

        // Line level follows the next state so it changes exactly on state edges.
        case (state_d)
            START:   tx_out_d = 1'b0;
            DATA:    tx_out_d = shift_d[0];
            PARITY:  tx_out_d = parity_d;
            default: tx_out_d = 1'b1;
        endcase
    end

    always_ff @(posedge Baud_Clk) begin
        if (Reset) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            hold_q   <= '0;
            hold_v_q <= 1'b0;
            parity_q <= 1'b0;
            cnt_q    <= '0;
            tx_out_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            hold_q   <= hold_d;
            hold_v_q <= hold_v_d;
            parity_q <= parity_d;
            cnt_q    <= cnt_d;
            tx_out_q <= tx_out_d;
        end
    end

    assign Tx_Out   = tx_out_q;
    assign Tx_Ready = !hold_v_q;
    assign Tx_Busy  = (state_q != IDLE);
    assign Tx_Done  = (state_q == STOP);

endmodule

// File: tb/tb_uart_transmitter.sv
// tb/tb_uart_transmitter.sv - self-checking bench for uart_transmitter (even and odd parity instances)
module tb_uart_transmitter;
    localparam int DW = 32;

    typedef struct {
        logic [DW-1:0] data;
        logic          exp_par;
    } vec_t;

    logic          Baud_Clk;
    logic          Reset;
    logic          tx_start_e, tx_start_o;
    logic [DW-1:0] tx_data_e, tx_data_o;
    logic          Tx_Out, Tx_Ready, Tx_Busy, Tx_Done;
    logic          out_o, ready_o, busy_o, done_o;

    uart_transmitter #(.DATA_WIDTH(DW), .PARITY_ODD(1'b0)) dut (
        .Baud_Clk (Baud_Clk),
        .Reset    (Reset),
        .Tx_Start (tx_start_e),
        .Tx_DataIn(tx_data_e),
        .Tx_Out   (Tx_Out),
        .Tx_Ready (Tx_Ready),
        .Tx_Busy  (Tx_Busy),
        .Tx_Done  (Tx_Done)
    );

    uart_transmitter #(.DATA_WIDTH(DW), .PARITY_ODD(1'b1)) dut_odd (
        .Baud_Clk (Baud_Clk),
        .Reset    (Reset),
        .Tx_Start (tx_start_o),
        .Tx_DataIn(tx_data_o),
        .Tx_Out   (out_o),
        .Tx_Ready (ready_o),
        .Tx_Busy  (busy_o),
        .Tx_Done  (done_o)
    );

    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    vec_t sb[$];
    int   start_q[$];
    int   stop_q[$];
    int   frames_seen = 0;
    int   busy_cnt = 0;
    logic rdy_log [0:8191];

    int            mon_phase = 0;
    int            mon_bit = 0;
    logic [DW-1:0] mon_word;
    logic          mon_par;

    initial begin
        Baud_Clk = 1'b0;
        forever #5 Baud_Clk = ~Baud_Clk;
    end

    always @(posedge Baud_Clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got time %0t, expected completion", $time);
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Frame decoder for the even-parity instance; compares each frame with the scoreboard head.
    always @(negedge Baud_Clk) begin
        if (Reset) begin
            mon_phase = 0;
        end else begin
            rdy_log[cyc % 8192] = Tx_Ready;
            if (Tx_Busy) busy_cnt++;
            check("done_level", Tx_Done, (mon_phase == 3));
            case (mon_phase)
                0: begin
                    if (Tx_Out === 1'b0) begin
                        start_q.push_back(cyc);
                        check("busy_at_start", Tx_Busy, 1);
                        mon_bit   = 0;
                        mon_phase = 1;
                    end
                end
                1: begin
                    mon_word[mon_bit] = Tx_Out;
                    mon_bit++;
                    if (mon_bit == DW) mon_phase = 2;
                end
                2: begin
                    mon_par   = Tx_Out;
                    mon_phase = 3;
                end
                default: begin
                    check("stop_bit", Tx_Out, 1);
                    stop_q.push_back(cyc);
                    frames_seen++;
                    tests++;
                    if (sb.size() == 0) begin
                        fails++;
                        $display("FAIL unexpected_frame: got word %0h, expected no frame", mon_word);
                    end else begin
                        vec_t e;
                        e = sb.pop_front();
                        check("frame_word", mon_word, e.data);
                        check("frame_parity", mon_par, e.exp_par);
                    end
                    mon_phase = 0;
                end
            endcase
        end
    end

    task automatic write_e(input logic [DW-1:0] d, output int acc);
        tx_start_e = 1'b1;
        tx_data_e  = d;
        @(posedge Baud_Clk);
        #1;
        acc        = cyc;
        tx_start_e = 1'b0;
    endtask

    task automatic write_o(input logic [DW-1:0] d);
        tx_start_o = 1'b1;
        tx_data_o  = d;
        @(posedge Baud_Clk);
        #1;
        tx_start_o = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        @(negedge Baud_Clk);
        while (Tx_Busy && n < 300) begin
            @(negedge Baud_Clk);
            n++;
        end
        if (n >= 300) begin
            tests++;
            fails++;
            $display("FAIL %s: got busy after %0d cycles, expected idle", name, n);
        end
        @(posedge Baud_Clk);
        #1;
    endtask

    initial begin
        vec_t vecs[6];
        int   acc, acc1, acc2, fr0, busy0, stop1, low_cnt, busy_hi;

        vecs[0] = '{32'hA5A5_0F01, 1'b1};
        vecs[1] = '{32'h0000_0001, 1'b1};
        vecs[2] = '{32'h0000_0003, 1'b0};
        vecs[3] = '{32'hFFFF_FFFE, 1'b1};
        vecs[4] = '{32'h8000_0000, 1'b1};
        vecs[5] = '{32'h0F0F_0F0F, 1'b0};

        Reset      = 1'b1;
        tx_start_e = 1'b0;
        tx_start_o = 1'b0;
        tx_data_e  = '0;
        tx_data_o  = '0;
        repeat (3) @(posedge Baud_Clk);
        #1;
        Reset = 1'b0;

        for (int i = 0; i < 5; i++) begin
            @(negedge Baud_Clk);
            check("idle_out", Tx_Out, 1);
            check("idle_ready", Tx_Ready, 1);
            check("idle_busy", Tx_Busy, 0);
            check("idle_done", Tx_Done, 0);
        end
        @(posedge Baud_Clk);
        #1;

        for (int i = 0; i < 6; i++) begin
            sb.push_back(vecs[i]);
            write_e(vecs[i].data, acc);
            wait_idle("vec_timeout");
            check("start_latency", start_q[$] - acc, 0);
            check("stop_latency", stop_q[$] - acc, DW + 2);
            check("sb_drained", sb.size(), 0);
        end

        // Chained frames: second word queued mid-frame, third write ignored.
        fr0   = frames_seen;
        busy0 = busy_cnt;
        sb.push_back('{32'hFFFF_FFFF, 1'b0});
        write_e(32'hFFFF_FFFF, acc1);
        repeat (4) @(posedge Baud_Clk);
        #1;
        sb.push_back('{32'h0000_0000, 1'b0});
        write_e(32'h0000_0000, acc2);
        @(negedge Baud_Clk);
        check("ready_after_hold", Tx_Ready, 0);
        @(posedge Baud_Clk);
        #1;
        write_e(32'hDEAD_BEEF, acc);
        @(negedge Baud_Clk);
        check("ready_still_full", Tx_Ready, 0);
        wait_idle("chain_timeout");
        check("chain_frames", frames_seen - fr0, 2);
        check("chain_no_gap", start_q[$] - stop_q[$-1], 1);
        check("chain_busy_cycles", busy_cnt - busy0, 70);
        stop1 = stop_q[$-1];
        check("ready_before_hold", rdy_log[(acc2 - 1) % 8192], 1);
        check("ready_at_stop1", rdy_log[stop1 % 8192], 0);
        check("ready_at_start2", rdy_log[(stop1 + 1) % 8192], 1);
        check("chain_sb_drained", sb.size(), 0);

        // Odd parity instance.
        write_o(32'h0000_0001);
        repeat (DW + 2) @(negedge Baud_Clk);
        check("odd_par_one", out_o, 0);
        @(negedge Baud_Clk);
        check("odd_stop", out_o, 1);
        check("odd_done", done_o, 1);
        @(posedge Baud_Clk);
        #1;
        write_o(32'h0000_0000);
        repeat (DW + 2) @(negedge Baud_Clk);
        check("odd_par_zero", out_o, 1);
        @(negedge Baud_Clk);
        check("odd_stop2", out_o, 1);
        @(posedge Baud_Clk);
        #1;

        // Reset mid-frame with a word queued.
        fr0 = frames_seen;
        sb.push_back('{32'hA5A5_0F01, 1'b1});
        write_e(32'hA5A5_0F01, acc);
        @(posedge Baud_Clk);
        #1;
        sb.push_back('{32'h1111_2222, 1'b0});
        write_e(32'h1111_2222, acc2);
        @(negedge Baud_Clk);
        check("rst_queued", Tx_Ready, 0);
        repeat (5) @(posedge Baud_Clk);
        #1;
        Reset = 1'b1;
        @(posedge Baud_Clk);
        #1;
        Reset = 1'b0;
        sb.delete();
        @(negedge Baud_Clk);
        check("rst_out", Tx_Out, 1);
        check("rst_ready", Tx_Ready, 1);
        check("rst_busy", Tx_Busy, 0);
        check("rst_done", Tx_Done, 0);
        low_cnt = 0;
        busy_hi = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge Baud_Clk);
            if (Tx_Out !== 1'b1) low_cnt++;
            if (Tx_Busy !== 1'b0) busy_hi++;
        end
        check("rst_line_quiet", low_cnt, 0);
        check("rst_no_busy", busy_hi, 0);
        check("rst_no_frames", frames_seen - fr0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
